rect_fill_scheduler: RTL
========================

# rect_fill_scheduler

Shares the VGA adapter's single pixel-write port among three drawing requesters: background, car draw/erase, and obstacle/overlay. Each requester posts a rectangle-fill command. The block grants requesters round-robin, walks the granted rectangle one pixel per clock in raster order, and drives the adapter's x, y, colour and plot inputs. It sits between the game control FSMs and the VGA adapter, and replaces per-FSM counterx/countery loops.

## Interface
- `X_W`, default 8: x coordinate width; screen is 160 columns.
- `Y_W`, default 7: y coordinate width; screen is 120 rows.
- `COLOUR_W`, default 3: colour width.
- `clock`  in  1: single clock; all state on its rising edge.
- `reset`  in  1: asynchronous, active-low; low clears all state immediately.
- `req`  in  3: per-requester request; held high until that requester's `done` bit pulses.
- `cmd_x`  in  3*X_W: rectangle left x, requester i at bits [i*X_W +: X_W].
- `cmd_y`  in  3*Y_W: rectangle top y, same packing.
- `cmd_w`  in  3*X_W: width in pixels; 0 is legal.
- `cmd_h`  in  3*Y_W: height in pixels; 0 is legal.
- `cmd_colour`  in  3*COLOUR_W: fill colour.
- `grant`  out  3: one-hot owner, high from LOAD through DONE.
- `done`  out  3: one-cycle pulse to the owner in DONE.
- `busy`  out  1: high whenever the state is not IDLE.
- `vga_x`  out  X_W: pixel x to the adapter.
- `vga_y`  out  Y_W: pixel y to the adapter.
- `vga_colour`  out  COLOUR_W: pixel colour to the adapter.
- `plot`  out  1: write enable to the adapter.

## Operation
- States:
  - IDLE: if any `req` bit is set, go to LOAD.
  - LOAD: latch the winner's command; go to FILL if w≠0 and h≠0, otherwise go to DONE.
  - FILL: step one pixel per cycle; after the last pixel go to DONE.
  - DONE: pulse `done`; go to IDLE.
- Arbitration happens in IDLE only.
  - Round-robin pointer `last` holds the most recently granted index.
  - Search order is last+1, last+2, last (mod 3).
  - `last` resets to 2, so requester 0 wins first.
  - `last` updates on the IDLE→LOAD transition.
- The command is latched in LOAD. Changes on `cmd_*` after LOAD are ignored until the next grant.
- Counters:
  - cx (X_W bits) and cy (Y_W bits) are cleared in LOAD.
  - cx increments each FILL cycle.
  - When cx == w−1, cx clears and cy increments.
  - FILL ends on the cycle where cx == w−1 and cy == h−1.
- Arithmetic:
  - px = x0 + cx and py = y0 + cy, computed at X_W+1 and Y_W+1 bits with no wrap.
  - `vga_x`/`vga_y` carry the low bits of px/py.
- Clipping: `plot` = FILL && px < 160 && py < 120.
  - Off-screen pixels still consume their cycle, so FILL length is always w·h.
- `vga_colour` is the latched colour during FILL and 0 otherwise. `vga_x`/`vga_y` are 0 outside FILL.
- A requester that holds `req` after its `done` is a new request, arbitrated fairly against the others.
- A `req` bit dropped before grant is ignored. Dropping `req` while granted does not abort the fill.

## Timing
- Reset values: state IDLE, `grant`=0, `done`=0, `busy`=0, `plot`=0, `vga_x`/`vga_y`/`vga_colour`=0, cx=cy=0, `last`=2.
- Reset asserted mid-FILL forces `plot` low asynchronously. The interrupted command is discarded with no `done`.
- Cycle sequence, with req sampled high in IDLE at cycle T:
  - LOAD is at T+1.
  - The first pixel is at T+2.
  - The last pixel is at T+1+w·h.
  - The `done` pulse is at T+2+w·h.
  - IDLE returns at T+3+w·h.
- Zero-size command: `done` at T+2.
- Outputs come from registered state, counters and latched command through one adder and a compare. The adapter samples them on the next rising edge.
- Back-to-back grants have a minimum 2-cycle gap (DONE, IDLE) with `plot`=0.

## Structure
- Shared package `draw_pkg`:
  - state localparams (IDLE=2'd0, LOAD=2'd1, FILL=2'd2, DONE=2'd3);
  - SCREEN_W=160, SCREEN_H=120;
  - colour constants (BLACK=3'b000, GREEN=3'b010, RED=3'b100).
- Sub-module `rr_arbiter3`: combinational, takes `req` and `last`, returns a one-hot winner and its index. It is unit-testable alone.
- Everything else (FSM, counters, clip, output mux) is in the top module.

## Test plan
- Single rectangle:
  - Stimulus: req0 with (10,20,w=4,h=3,colour 3'b010).
  - Required: 12 `plot` cycles, raster order (10,20),(11,20),…,(13,22); `done[0]` exactly at T+14; `busy` low at T+15.
- Zero size:
  - Stimulus: req1 with w=0, h=5.
  - Required: no `plot`; `done[1]` at T+2.
- Clipping:
  - Stimulus: req2 at (158,118), w=4, h=4.
  - Required: 16 FILL cycles; `plot` only for (158,118),(159,118),(158,119),(159,119).
- Round-robin:
  - Stimulus: all three req held continuously, each with 1×1 commands.
  - Required: grant order 0,1,2,0,1,2; no requester granted twice while another waits.
- Reset mid-fill:
  - Stimulus: `reset` low during pixel 5 of a 10×10 fill.
  - Required: `plot`, `grant`, `busy` drop without waiting for a clock edge; no `done`; after release, the pending req0 is granted first.
- Full screen:
  - Stimulus: (0,0,160,120) green.
  - Required: exactly 19200 `plot` cycles; last pixel (159,119); `done` one cycle later.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared drawing definitions: FSM state encoding, screen geometry, palette.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] RED   = 3'b100;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin pick: search order last+1, last+2, last (mod 3).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
module rr_arbiter3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] win,
    output logic [1:0] win_idx,
    output logic       win_vld
);

    logic [1:0] o0, o1, o2;

    // Priority order rotates so the most recent winner is searched last.
    always_comb begin
        case (last)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
    end

    // First requester in rotated order wins; one-hot is derived from the index.
    always_comb begin
        win_vld = |req;
        win_idx = 2'd0;
        win     = 3'b000;
        if (req[o0])      win_idx = o0;
        else if (req[o1]) win_idx = o1;
        else if (req[o2]) win_idx = o2;
        if (win_vld) win = 3'(3'b001 << win_idx);
    end

endmodule

// File: rtl/rect_fill_scheduler.sv
// Shares one pixel-write port among three rectangle-fill requesters, round-robin.
// Latency: grant 1 cycle after req seen in IDLE, first pixel 2 cycles, done at 2+w*h.
// Backpressure: none; requesters hold req until their done pulse, the adapter never stalls.
module rect_fill_scheduler
    import draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [3*X_W-1:0]      cmd_x,
    input  logic [3*Y_W-1:0]      cmd_y,
    input  logic [3*X_W-1:0]      cmd_w,
    input  logic [3*Y_W-1:0]      cmd_h,
    input  logic [3*COLOUR_W-1:0] cmd_colour,
    output logic [2:0]            grant,
    output logic [2:0]            done,
    output logic                  busy,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [COLOUR_W-1:0]   vga_colour,
    output logic                  plot
);

    state_t              state, state_nxt;
    logic [1:0]          last;
    logic [2:0]          owner;
    logic [X_W-1:0]      x0, w, cx;
    logic [Y_W-1:0]      y0, h, cy;
    logic [COLOUR_W-1:0] col;

    logic [2:0]          arb_win;
    logic [1:0]          arb_idx;
    logic                arb_vld;

    logic [X_W-1:0]      sel_w;
    logic [Y_W-1:0]      sel_h;
    logic [X_W:0]        px;
    logic [Y_W:0]        py;
    logic                row_end, rect_end, in_fill;

    rr_arbiter3 u_arb (
        .req     (req),
        .last    (last),
        .win     (arb_win),
        .win_idx (arb_idx),
        .win_vld (arb_vld)
    );

    // While in LOAD, 'last' already names the owner, so it selects the command slice.
    assign sel_w    = cmd_w[last*X_W +: X_W];
    assign sel_h    = cmd_h[last*Y_W +: Y_W];

    // Pixel address is one level wider than the screen so off-screen sums never wrap on-screen.
    assign px       = {1'b0, x0} + {1'b0, cx};
    assign py       = {1'b0, y0} + {1'b0, cy};
    assign row_end  = (cx == w - X_W'(1));
    assign rect_end = row_end && (cy == h - Y_W'(1));
    assign in_fill  = (state == FILL);

    // Next-state: arbitrate in IDLE, skip FILL for empty rectangles.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (arb_vld) state_nxt = LOAD;
            LOAD: state_nxt = (sel_w != '0 && sel_h != '0) ? FILL : DONE;
            FILL: if (rect_end) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Arbitration pointer, command latch and raster counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last  <= 2'd2;
            owner <= 3'b000;
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            col   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            case (state)
                IDLE: if (arb_vld) begin
                    last  <= arb_idx;
                    owner <= arb_win;
                end
                LOAD: begin
                    x0  <= cmd_x[last*X_W +: X_W];
                    y0  <= cmd_y[last*Y_W +: Y_W];
                    w   <= sel_w;
                    h   <= sel_h;
                    col <= cmd_colour[last*COLOUR_W +: COLOUR_W];
                    cx  <= '0;
                    cy  <= '0;
                end
                FILL: begin
                    if (row_end) begin
                        cx <= '0;
                        cy <= cy + Y_W'(1);
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode directly from state so reset removes them without a clock edge.
    always_comb begin
        busy       = (state != IDLE);
        grant      = busy ? owner : 3'b000;
        done       = (state == DONE) ? owner : 3'b000;
        plot       = in_fill && (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));
        vga_x      = in_fill ? px[X_W-1:0] : '0;
        vga_y      = in_fill ? py[Y_W-1:0] : '0;
        vga_colour = in_fill ? col : '0;
    end

endmodule
